// File: rtl/time_display_scanner_if.sv
// Bus between the time/mode source and the display scanner.
// Carries the binary time fields and set-mode in, segment/anode/dp drive out.
// No handshake: the inputs are level signals sampled once per display frame.
interface time_display_scanner_if;
  logic [13:0] hour;
  logic [13:0] minute;
  logic [13:0] second;
  logic [1:0]  mode;
  logic [6:0]  seg;
  logic [5:0]  an;
  logic        dp;

  // Time keeper / switch FSM side
  modport master (
    output hour, minute, second, mode,
    input  seg, an, dp
  );

  // Display scanner side
  modport slave (
    input  hour, minute, second, mode,
    output seg, an, dp
  );
endinterface

// File: rtl/time_display_scanner.sv
// Multiplexed 6-digit 7-segment driver with per-frame binary->BCD conversion.
// Latency: seg/an/dp lag the scan index by one clock; new values commit <=41 clocks after frame start.
// Backpressure: none; inputs are snapshot at frame start, changes in between are ignored.
module time_display_scanner #(
  parameter int SCAN_DIV  = 8,
  parameter int BLINK_DIV = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  time_display_scanner_if.slave bus
);

  localparam int CW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAP,
    S_CONV_S,
    S_CONV_M,
    S_CONV_H,
    S_COMMIT
  } state_t;

  // Scan position
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic          w_frame_start;

  // Blink
  logic [BW-1:0] r_bcnt;
  logic          r_phase;
  logic [1:0]    r_mode_prev;
  logic          w_mode_chg;
  logic          w_phase_eff;

  // Converter
  state_t        r_state;
  state_t        w_state_nxt;
  logic [13:0]   r_snap_h;
  logic [13:0]   r_snap_m;
  logic [13:0]   r_snap_s;
  logic [2:0]    r_oor;        // {h, m, s} out-of-range flags of the frame in flight
  logic [6:0]    r_rem;
  logic [3:0]    r_tens;
  logic          w_ge10;
  logic [3:0]    r_stg_s_t, r_stg_s_u;
  logic [3:0]    r_stg_m_t, r_stg_m_u;
  logic [3:0]    r_stg_h_t, r_stg_h_u;

  // Digits currently on display (only ever written together in COMMIT)
  logic [3:0]    r_dig_s_t, r_dig_s_u;
  logic [3:0]    r_dig_m_t, r_dig_m_u;
  logic [3:0]    r_dig_h_t, r_dig_h_u;
  logic [2:0]    r_dsp_oor;

  // Output stage
  logic [1:0]    w_field;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg;
  logic          w_blank;
  logic [6:0]    r_seg;
  logic [5:0]    r_an;
  logic          r_dp;

  assign w_frame_start = (r_idx == 3'd0) && (r_cnt == '0);
  assign w_mode_chg    = (bus.mode != r_mode_prev);
  // A mode change restarts the blink cycle in the visible phase immediately.
  assign w_phase_eff   = w_mode_chg ? 1'b0 : r_phase;
  assign w_ge10        = (r_rem >= 7'd10);
  assign w_field       = r_idx[2:1];

  // Scan counters: each digit dwells SCAN_DIV clocks, six digits per frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 3'd0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Blink half-period timer, restarted on any mode change
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bcnt      <= '0;
      r_phase     <= 1'b0;
      r_mode_prev <= bus.mode;
    end else begin
      r_mode_prev <= bus.mode;
      if (w_mode_chg) begin
        r_bcnt  <= '0;
        r_phase <= 1'b0;
      end else if (r_bcnt == BLK_LAST) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end

  // Converter FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Converter FSM next state: S, M, H are divided in turn by repeated subtraction
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_frame_start) w_state_nxt = S_CAP;
      S_CAP:    w_state_nxt = S_CONV_S;
      S_CONV_S: if (!w_ge10) w_state_nxt = S_CONV_M;
      S_CONV_M: if (!w_ge10) w_state_nxt = S_CONV_H;
      S_CONV_H: if (!w_ge10) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Converter datapath: snapshot, divide-by-10, stage, then commit all digits at once
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_snap_h  <= '0;
      r_snap_m  <= '0;
      r_snap_s  <= '0;
      r_oor     <= '0;
      r_rem     <= '0;
      r_tens    <= '0;
      r_stg_s_t <= '0;
      r_stg_s_u <= '0;
      r_stg_m_t <= '0;
      r_stg_m_u <= '0;
      r_stg_h_t <= '0;
      r_stg_h_u <= '0;
      r_dig_s_t <= '0;
      r_dig_s_u <= '0;
      r_dig_m_t <= '0;
      r_dig_m_u <= '0;
      r_dig_h_t <= '0;
      r_dig_h_u <= '0;
      r_dsp_oor <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_frame_start) begin
            r_snap_h <= bus.hour;
            r_snap_m <= bus.minute;
            r_snap_s <= bus.second;
          end
        end
        S_CAP: begin
          r_oor  <= {(r_snap_h > 14'd99), (r_snap_m > 14'd99), (r_snap_s > 14'd99)};
          r_rem  <= r_snap_s[6:0];
          r_tens <= '0;
        end
        S_CONV_S: begin
          if (w_ge10) begin
            r_rem  <= r_rem - 7'd10;
            r_tens <= r_tens + 4'd1;
          end else begin
            r_stg_s_t <= r_tens;
            r_stg_s_u <= r_rem[3:0];
            r_rem     <= r_snap_m[6:0];
            r_tens    <= '0;
          end
        end
        S_CONV_M: begin
          if (w_ge10) begin
            r_rem  <= r_rem - 7'd10;
            r_tens <= r_tens + 4'd1;
          end else begin
            r_stg_m_t <= r_tens;
            r_stg_m_u <= r_rem[3:0];
            r_rem     <= r_snap_h[6:0];
            r_tens    <= '0;
          end
        end
        S_CONV_H: begin
          if (w_ge10) begin
            r_rem  <= r_rem - 7'd10;
            r_tens <= r_tens + 4'd1;
          end else begin
            r_stg_h_t <= r_tens;
            r_stg_h_u <= r_rem[3:0];
          end
        end
        S_COMMIT: begin
          r_dig_s_t <= r_stg_s_t;
          r_dig_s_u <= r_stg_s_u;
          r_dig_m_t <= r_stg_m_t;
          r_dig_m_u <= r_stg_m_u;
          r_dig_h_t <= r_stg_h_t;
          r_dig_h_u <= r_stg_h_u;
          r_dsp_oor <= r_oor;
        end
        default: begin
          r_rem <= '0;
        end
      endcase
    end
  end

  // Select the digit for the current scan slot and decode it to segments
  always_comb begin
    w_digit = 4'd0;
    case (r_idx)
      3'd0:    w_digit = r_dig_s_u;
      3'd1:    w_digit = r_dig_s_t;
      3'd2:    w_digit = r_dig_m_u;
      3'd3:    w_digit = r_dig_m_t;
      3'd4:    w_digit = r_dig_h_u;
      3'd5:    w_digit = r_dig_h_t;
      default: w_digit = 4'd0;
    endcase
    w_seg = SEG_OFF;
    case (w_digit)
      4'd0:    w_seg = 7'b1000000;
      4'd1:    w_seg = 7'b1111001;
      4'd2:    w_seg = 7'b0100100;
      4'd3:    w_seg = 7'b0110000;
      4'd4:    w_seg = 7'b0011001;
      4'd5:    w_seg = 7'b0010010;
      4'd6:    w_seg = 7'b0000010;
      4'd7:    w_seg = 7'b1111000;
      4'd8:    w_seg = 7'b0000000;
      4'd9:    w_seg = 7'b0010000;
      default: w_seg = SEG_OFF;
    endcase
    if (r_dsp_oor[w_field]) begin
      w_seg = SEG_DASH;
    end
    w_blank = w_phase_eff && (bus.mode != 2'd0) && (w_field == (bus.mode - 2'd1));
  end

  // Registered display drive; the field being set is blanked during blink phase 1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_an  <= 6'b111111;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_blank ? 6'b111111 : ~(6'b000001 << r_idx);
      r_seg <= w_seg;
      r_dp  <= !((r_idx == 3'd2) || (r_idx == 3'd4));
    end
  end

  assign bus.seg = r_seg;
  assign bus.an  = r_an;
  assign bus.dp  = r_dp;

endmodule

// File: tb/tb_time_display_scanner.sv
// Scoreboard bench: a cycle-level reference model pushes the expected display drive
// each clock; a negedge monitor pops and compares. Directed slot checks sit on top.
module tb_time_display_scanner;
  localparam int S = 8;
  localparam int B = 64;
  localparam int F = 6 * S;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  time_display_scanner_if bus_if ();

  time_display_scanner #(.SCAN_DIV(S), .BLINK_DIV(B)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } obs_t;

  obs_t exp_q[$];

  // Reference model state: time in clocks since reset release, displayed values as integers
  int         t = 0;
  int         commit_at = 0;
  bit         pending = 1'b0;
  int         disp[3];   // 0 sec, 1 min, 2 hour
  int         snap[3];
  int         origin = 0;
  logic [1:0] prev_mode = 2'd0;

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tab [10];
    tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return tab[d];
  endfunction

  function automatic int conv_cycles(input int v);
    return ((v % 128) / 10) + 1;
  endfunction

  // Reference model: predicts what the DUT drives after this rising edge
  always @(posedge clk) begin : model
    obs_t e;
    int   pos, fld, val, ph;
    bit   chg;
    if (!rst_n) begin
      e         = {6'b111111, 7'b1111111, 1'b1};
      t         = 0;
      pending   = 1'b0;
      disp      = '{0, 0, 0};
      origin    = 0;
      prev_mode = bus_if.mode;
    end else begin
      chg       = (bus_if.mode != prev_mode);
      prev_mode = bus_if.mode;
      ph        = chg ? 0 : (((t - origin) / B) % 2);
      if (chg) origin = t + 1;
      pos = (t / S) % 6;
      fld = pos / 2;
      val = disp[fld];
      e.seg = (val > 99) ? 7'b0111111 : seg_of((pos % 2 == 1) ? (val / 10) % 10 : val % 10);
      e.dp  = (pos == 2 || pos == 4) ? 1'b0 : 1'b1;
      if (ph == 1 && bus_if.mode != 2'd0 && fld == int'(bus_if.mode) - 1)
        e.an = 6'b111111;
      else
        e.an = ~(6'b000001 << pos);
      if (pending && t == commit_at) begin
        disp    = snap;
        pending = 1'b0;
      end
      if (t % F == 0) begin
        snap[0]   = int'(bus_if.second);
        snap[1]   = int'(bus_if.minute);
        snap[2]   = int'(bus_if.hour);
        commit_at = t + 2 + conv_cycles(snap[0]) + conv_cycles(snap[1]) + conv_cycles(snap[2]);
        pending   = 1'b1;
      end
      t++;
    end
    exp_q.push_back(e);
  end

  // Monitor: every clock the DUT presents a display drive, compare against the model
  always @(negedge clk) begin : monitor
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus_if.an, bus_if.seg, bus_if.dp};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL scan @%0t: got an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                 $time, a.an, a.seg, a.dp, e.an, e.seg, e.dp);
      end
    end
  end

  // Wait (bounded) until digit pos is lit, then check its segments and dp
  task automatic check_slot(input int pos, input logic [6:0] want_seg, input logic want_dp,
                            input string name);
    int n;
    logic [5:0] want_an;
    want_an = ~(6'b000001 << pos);
    n = 0;
    while (n < 4 * F && bus_if.an !== want_an) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 4 * F) begin
      bad++;
      $display("FAIL %s: digit %0d never lit, an=%b", name, pos, bus_if.an);
    end else if (bus_if.seg !== want_seg || bus_if.dp !== want_dp) begin
      bad++;
      $display("FAIL %s: seg=%b dp=%b, required seg=%b dp=%b",
               name, bus_if.seg, bus_if.dp, want_seg, want_dp);
    end
  endtask

  // Wait (bounded) for a given offset within the frame, as seen at a falling edge
  task automatic wait_frame_offset(input int k);
    int n;
    n = 0;
    while (n < 2 * F && (t % F) != k) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2 * F) begin
      total++;
      bad++;
      $display("FAIL frame_wait: offset %0d not reached, t=%0d", k, t);
    end
  endtask

  task automatic check_post_reset(input string name);
    total++;
    if (bus_if.an !== 6'b111110 || bus_if.seg !== 7'b1000000) begin
      bad++;
      $display("FAIL %s: an=%b seg=%b, required an=111110 seg=1000000",
               name, bus_if.an, bus_if.seg);
    end
  endtask

  initial begin
    bus_if.hour   = 14'd0;
    bus_if.minute = 14'd0;
    bus_if.second = 14'd0;
    bus_if.mode   = 2'd0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus_if.an !== 6'b111111 || bus_if.seg !== 7'b1111111 || bus_if.dp !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: an=%b seg=%b dp=%b, required 111111 1111111 1",
               bus_if.an, bus_if.seg, bus_if.dp);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_post_reset("reset_release");

    // Normal display 23:59:57
    bus_if.hour   = 14'd23;
    bus_if.minute = 14'd59;
    bus_if.second = 14'd57;
    repeat (2 * F) @(negedge clk);
    check_slot(0, 7'b1111000, 1'b1, "norm_s_u");
    check_slot(1, 7'b0010010, 1'b1, "norm_s_t");
    check_slot(2, 7'b0010000, 1'b0, "norm_m_u");
    check_slot(3, 7'b0010010, 1'b1, "norm_m_t");
    check_slot(4, 7'b0110000, 1'b0, "norm_h_u");
    check_slot(5, 7'b0100100, 1'b1, "norm_h_t");

    // Out-of-range hour
    bus_if.hour = 14'd100;
    repeat (2 * F) @(negedge clk);
    check_slot(4, 7'b0111111, 1'b0, "oor_h_u");
    check_slot(5, 7'b0111111, 1'b1, "oor_h_t");
    check_slot(2, 7'b0010000, 1'b0, "oor_m_u");

    // Blink on seconds, then switch to hours during the blanked phase
    bus_if.mode = 2'd1;
    repeat (B + 10) @(negedge clk);
    bus_if.mode = 2'd3;
    repeat (3 * B) @(negedge clk);

    // Mid-frame change of seconds
    bus_if.mode   = 2'd0;
    bus_if.hour   = 14'd23;
    bus_if.second = 14'd10;
    repeat (2 * F) @(negedge clk);
    wait_frame_offset(20);
    bus_if.second = 14'd59;
    repeat (2 * F) @(negedge clk);
    check_slot(0, 7'b0010000, 1'b1, "mid_s_u");
    check_slot(1, 7'b0010010, 1'b1, "mid_s_t");

    // Reset in the middle of a conversion
    bus_if.hour   = 14'd12;
    bus_if.minute = 14'd34;
    bus_if.second = 14'd56;
    wait_frame_offset(5);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_post_reset("reset_mid_conv");
    repeat (2 * F) @(negedge clk);
    check_slot(3, 7'b0110000, 1'b1, "after_rst_m_t");

    // Randomized traffic, including large values and occasional resets
    for (int it = 0; it < 40; it++) begin
      bus_if.hour   = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(0, 16383)) : 14'($urandom_range(0, 99));
      bus_if.minute = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(0, 16383)) : 14'($urandom_range(0, 99));
      bus_if.second = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(0, 16383)) : 14'($urandom_range(0, 99));
      if ($urandom_range(0, 2) == 0) bus_if.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst_n = 1'b1;
      end
      repeat ($urandom_range(1, 150)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
